// File: rtl/pc_gen_pkg.sv
// Shared definitions for the PC-generation stage: FSM state encoding,
// default reset vector and the alignment helper used on redirect targets.
package pc_gen_pkg;

  typedef enum logic [1:0] {
    PCG_BOOT = 2'd0,
    PCG_RUN  = 2'd1,
    PCG_HALT = 2'd2,
    PCG_TRAP = 2'd3
  } pcg_state_e;

  localparam logic [31:0] PCG_DEFAULT_RESET_PC = 32'h0000_0000;

  function automatic logic pcg_is_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/mux2to1.sv
// Generic two-input multiplexer: y = sel ? d1 : d0.
module mux2to1 #(
  parameter int k = 32
) (
  input  logic [k-1:0] d0,
  input  logic [k-1:0] d1,
  input  logic         sel,
  output logic [k-1:0] y
);

  assign y = sel ? d1 : d0;

endmodule

// File: rtl/pc_gen.sv
// Program-counter generation: holds the fetch PC, selects the next PC from
// pc_plus4 / jump / branch, and tracks BOOT/RUN/HALT/TRAP for the fetch unit.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter logic [31:0] RESET_PC = PCG_DEFAULT_RESET_PC,
  parameter int          CNT_W    = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Run,
  input  logic             stall,
  input  logic [31:0]      pc_plus4,
  input  logic             branch_taken,
  input  logic [31:0]      branch_pc,
  input  logic             jump,
  input  logic [31:0]      jump_pc,
  input  logic             halt,
  output logic [31:0]      pc,
  output logic             fetch_valid,
  output logic             flush_if,
  output logic             halted,
  output logic             misalign,
  output logic [CNT_W-1:0] fetch_cnt
);

  pcg_state_e       state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [31:0] seq_or_jump;
  logic [31:0] next_pc;
  logic        redirect;

  // Branch sits in the outer mux so it wins over a simultaneous jump (EX is older).
  mux2to1 #(.k(32)) u_mux_jump (
    .d0  (pc_plus4),
    .d1  (jump_pc),
    .sel (jump),
    .y   (seq_or_jump)
  );

  mux2to1 #(.k(32)) u_mux_branch (
    .d0  (seq_or_jump),
    .d1  (branch_pc),
    .sel (branch_taken),
    .y   (next_pc)
  );

  assign redirect = branch_taken | jump;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    pc_d        = pc_q;
    cnt_d       = cnt_q;
    fetch_valid = 1'b0;
    flush_if    = 1'b0;

    unique case (state_q)
      PCG_BOOT: begin
        if (Run) state_d = PCG_RUN;
      end
      PCG_RUN: begin
        if (Run) begin
          fetch_valid = 1'b1;
          if (!stall && !halt) cnt_d = cnt_q + CNT_W'(1);
          if (redirect) begin
            if (pcg_is_aligned(next_pc)) begin
              flush_if = 1'b1;
              pc_d     = next_pc;
            end else begin
              state_d = PCG_TRAP;
            end
          end else if (halt) begin
            state_d = PCG_HALT;
          end else if (!stall) begin
            pc_d = next_pc;
          end
        end
      end
      default: ;  // HALT and TRAP are frozen until reset
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge Clk) begin
    // NOTE: reset is synchronous: Rst is only looked at on the rising clock edge.
    if (Rst) state_q <= PCG_BOOT;
    else     state_q <= state_d;
  end

  always_ff @(posedge Clk) begin
    if (Rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end

  always_ff @(posedge Clk) begin
    if (Rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign pc        = pc_q;
  assign fetch_cnt = cnt_q;
  assign halted    = (state_q == PCG_HALT);
  assign misalign  = (state_q == PCG_TRAP);

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: a directed cycle table for the named corner
// cases, then randomized traffic compared against a behavioural model.
module tb_pc_gen;

  logic        Clk = 1'b0;
  logic        Rst, Run, stall, branch_taken, jump, halt;
  logic [31:0] pc_plus4, branch_pc, jump_pc;
  logic [31:0] pc, fetch_cnt;
  logic        fetch_valid, flush_if, halted, misalign;

  int n_tests = 0;
  int n_fail  = 0;

  pc_gen #(.RESET_PC(32'h0), .CNT_W(32)) dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .Run          (Run),
    .stall        (stall),
    .pc_plus4     (pc_plus4),
    .branch_taken (branch_taken),
    .branch_pc    (branch_pc),
    .jump         (jump),
    .jump_pc      (jump_pc),
    .halt         (halt),
    .pc           (pc),
    .fetch_valid  (fetch_valid),
    .flush_if     (flush_if),
    .halted       (halted),
    .misalign     (misalign),
    .fetch_cnt    (fetch_cnt)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // One row = inputs applied for a cycle plus the outputs expected during that cycle.
  typedef struct {
    logic        rst, run, stall, br;
    logic [31:0] bpc;
    logic        jmp;
    logic [31:0] jpc;
    logic        halt;
    logic [31:0] pp4;
    logic [31:0] pc;
    logic        fv, fl, hlt, mis;
    logic [31:0] cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(logic rst, logic run, logic stl, logic br, logic [31:0] bpc,
                             logic jmp, logic [31:0] jpc, logic hlt_in, logic [31:0] pp4,
                             logic [31:0] e_pc, logic e_fv, logic e_fl, logic e_hlt,
                             logic e_mis, logic [31:0] e_cnt);
    vec_t r;
    r.rst = rst; r.run = run; r.stall = stl; r.br = br; r.bpc = bpc;
    r.jmp = jmp; r.jpc = jpc; r.halt = hlt_in; r.pp4 = pp4;
    r.pc = e_pc; r.fv = e_fv; r.fl = e_fl; r.hlt = e_hlt; r.mis = e_mis; r.cnt = e_cnt;
    return r;
  endfunction

  task automatic drive(input logic rst, input logic run, input logic stl, input logic br,
                       input logic [31:0] bpc, input logic jmp, input logic [31:0] jpc,
                       input logic hlt_in, input logic [31:0] pp4);
    Rst = rst; Run = run; stall = stl; branch_taken = br; branch_pc = bpc;
    jump = jmp; jump_pc = jpc; halt = hlt_in; pc_plus4 = pp4;
  endtask

  task automatic check_outputs(input string tag, input logic [31:0] e_pc, input logic e_fv,
                               input logic e_fl, input logic e_hlt, input logic e_mis,
                               input logic [31:0] e_cnt);
    check({tag, ".pc"},          pc,                  e_pc);
    check({tag, ".fetch_valid"}, {31'd0, fetch_valid}, {31'd0, e_fv});
    check({tag, ".flush_if"},    {31'd0, flush_if},    {31'd0, e_fl});
    check({tag, ".halted"},      {31'd0, halted},      {31'd0, e_hlt});
    check({tag, ".misalign"},    {31'd0, misalign},    {31'd0, e_mis});
    check({tag, ".fetch_cnt"},   fetch_cnt,           e_cnt);
  endtask

  // Behavioural model for the random phase.
  typedef enum {M_BOOT, M_RUN, M_HALT, M_TRAP} mode_e;
  mode_e       m_mode;
  logic [31:0] m_pc;
  logic [31:0] m_cnt;

  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    repeat (2) @(negedge Clk);

    //     rst run stl br  bpc           jmp jpc           hlt pp4            pc            fv fl hl ms cnt
    vecs.push_back(v(0, 1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h4,         32'h0,        0, 0, 0, 0, 0));
    vecs.push_back(v(0, 1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h4,         32'h0,        1, 0, 0, 0, 0));
    vecs.push_back(v(0, 1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h8,         32'h4,        1, 0, 0, 0, 1));
    vecs.push_back(v(0, 1, 0, 0, 32'h0,        0, 32'h0,        0, 32'hC,         32'h8,        1, 0, 0, 0, 2));
    vecs.push_back(v(0, 1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h10,        32'hC,        1, 0, 0, 0, 3));
    // branch + jump + stall together: branch wins, flush now
    vecs.push_back(v(0, 1, 1, 1, 32'h40,       1, 32'h80,       0, 32'h14,        32'h10,       1, 1, 0, 0, 4));
    vecs.push_back(v(0, 1, 0, 0, 32'h0,        1, 32'h20,       0, 32'h44,        32'h40,       1, 1, 0, 0, 4));
    // three stall cycles at 0x20
    vecs.push_back(v(0, 1, 1, 0, 32'h0,        0, 32'h0,        0, 32'h24,        32'h20,       1, 0, 0, 0, 5));
    vecs.push_back(v(0, 1, 1, 0, 32'h0,        0, 32'h0,        0, 32'h24,        32'h20,       1, 0, 0, 0, 5));
    vecs.push_back(v(0, 1, 1, 0, 32'h0,        0, 32'h0,        0, 32'h24,        32'h20,       1, 0, 0, 0, 5));
    vecs.push_back(v(0, 1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h24,        32'h20,       1, 0, 0, 0, 5));
    vecs.push_back(v(0, 1, 0, 0, 32'h0,        1, 32'h30,       0, 32'h28,        32'h24,       1, 1, 0, 0, 6));
    // halt at 0x30, then redirects are ignored
    vecs.push_back(v(0, 1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h34,        32'h30,       1, 0, 0, 0, 7));
    vecs.push_back(v(0, 1, 0, 1, 32'h40,       0, 32'h0,        0, 32'h34,        32'h30,       0, 0, 1, 0, 7));
    vecs.push_back(v(0, 1, 1, 1, 32'h50,       1, 32'h60,       1, 32'h34,        32'h30,       0, 0, 1, 0, 7));
    vecs.push_back(v(1, 1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h34,        32'h30,       0, 0, 1, 0, 7));
    vecs.push_back(v(0, 1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h4,         32'h0,        0, 0, 0, 0, 0));
    vecs.push_back(v(0, 1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h4,         32'h0,        1, 0, 0, 0, 0));
    // Run=0 for two cycles freezes everything, even a branch
    vecs.push_back(v(0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h8,         32'h4,        0, 0, 0, 0, 1));
    vecs.push_back(v(0, 0, 0, 1, 32'h40,       0, 32'h0,        0, 32'h8,         32'h4,        0, 0, 0, 0, 1));
    vecs.push_back(v(0, 1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h8,         32'h4,        1, 0, 0, 0, 1));
    // misaligned jump: no flush, TRAP, pc holds
    vecs.push_back(v(0, 1, 0, 0, 32'h0,        1, 32'h102,      0, 32'hC,         32'h8,        1, 0, 0, 0, 2));
    vecs.push_back(v(0, 1, 0, 0, 32'h0,        0, 32'h0,        0, 32'hC,         32'h8,        0, 0, 0, 1, 3));
    vecs.push_back(v(0, 1, 0, 1, 32'h40,       0, 32'h0,        0, 32'hC,         32'h8,        0, 0, 0, 1, 3));
    // wrap from 0xFFFF_FFFC to 0 without trapping
    vecs.push_back(v(1, 1, 0, 0, 32'h0,        0, 32'h0,        0, 32'hC,         32'h8,        0, 0, 0, 1, 3));
    vecs.push_back(v(0, 1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h4,         32'h0,        0, 0, 0, 0, 0));
    vecs.push_back(v(0, 1, 0, 0, 32'h0,        1, 32'hFFFF_FFFC, 0, 32'h4,        32'h0,        1, 1, 0, 0, 0));
    vecs.push_back(v(0, 1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,         32'hFFFF_FFFC, 1, 0, 0, 0, 1));
    vecs.push_back(v(0, 1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h4,         32'h0,        1, 0, 0, 0, 2));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge Clk);
      drive(vecs[i].rst, vecs[i].run, vecs[i].stall, vecs[i].br, vecs[i].bpc,
            vecs[i].jmp, vecs[i].jpc, vecs[i].halt, vecs[i].pp4);
      #1;
      check_outputs($sformatf("vec%0d", i), vecs[i].pc, vecs[i].fv, vecs[i].fl,
                    vecs[i].hlt, vecs[i].mis, vecs[i].cnt);
    end

    // Random phase: start from a known reset, then let the model predict every cycle.
    @(negedge Clk);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    m_mode = M_BOOT; m_pc = 32'h0; m_cnt = 32'h0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      logic        r_rst, r_run, r_stl, r_br, r_jmp, r_hlt, e_fv, e_fl;
      logic [31:0] r_bpc, r_jpc, tgt;
      @(negedge Clk);
      r_rst = ($urandom_range(0, 29) == 0);
      r_run = ($urandom_range(0, 7) != 0);
      r_stl = ($urandom_range(0, 4) == 0);
      r_br  = ($urandom_range(0, 5) == 0);
      r_jmp = ($urandom_range(0, 5) == 0);
      r_hlt = ($urandom_range(0, 15) == 0);
      r_bpc = {$urandom_range(0, 32'hFFFF), 16'h0} | ($urandom_range(0, 7) == 0 ? 32'h2 : 32'h0);
      r_jpc = {16'h0, 16'($urandom)} & (($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
      drive(r_rst, r_run, r_stl, r_br, r_bpc, r_jmp, r_jpc, r_hlt, m_pc + 32'd4);

      tgt  = r_br ? r_bpc : r_jpc;
      e_fv = (m_mode == M_RUN) && r_run;
      e_fl = e_fv && (r_br || r_jmp) && (tgt % 4 == 0);
      #1;
      check_outputs($sformatf("rnd%0d", cyc), m_pc, e_fv, e_fl,
                    m_mode == M_HALT, m_mode == M_TRAP, m_cnt);

      if (r_rst) begin
        m_mode = M_BOOT; m_pc = 32'h0; m_cnt = 32'h0;
      end else if (m_mode == M_BOOT && r_run) begin
        m_mode = M_RUN;
      end else if (m_mode == M_RUN && r_run) begin
        if (!r_stl && !r_hlt) m_cnt = m_cnt + 1;
        if (r_br || r_jmp) begin
          if (tgt % 4 != 0) m_mode = M_TRAP;
          else              m_pc   = tgt;
        end else if (r_hlt) begin
          m_mode = M_HALT;
        end else if (!r_stl) begin
          m_pc = m_pc + 4;
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
